// File: rtl/joy_db9_serial_reader.sv
// Serial reader for a 74HC165-style DB9/JAMMA joystick chain: drives load/clock,
// shifts in 16 bits per frame and publishes them only after two identical frames.
module joy_db9_serial_reader #(
  parameter int unsigned CLK_DIV   = 25,
  parameter int unsigned GAP_TICKS = 30
) (
  input  logic       clk50mhz,
  input  logic       reset_n,
  input  logic       joy_data,
  output logic       joy_clk,
  output logic       joy_load_n,
  output logic       joy_select,
  output logic [7:0] joy1,
  output logic [7:0] joy2,
  output logic       frame_valid
);

  localparam int unsigned DIV_W   = 8;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned BIT_W   = 4;
  localparam int unsigned FRAME_W = 16;

  localparam logic [2:0] ST_LOAD     = 3'd0;
  localparam logic [2:0] ST_SHIFT_LO = 3'd1;
  localparam logic [2:0] ST_SHIFT_HI = 3'd2;
  localparam logic [2:0] ST_COMPARE  = 3'd3;
  localparam logic [2:0] ST_GAP      = 3'd4;

  logic [1:0]         sync_q;
  logic [DIV_W-1:0]   div_q,    div_d;
  logic [2:0]         state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [BIT_W-1:0]   bit_q,    bit_d;
  logic [FRAME_W-1:0] shreg_q,  shreg_d;
  logic [FRAME_W-1:0] prev_q,   prev_d;
  logic [7:0]         joy1_q,   joy1_d;
  logic [7:0]         joy2_q,   joy2_d;
  logic               fv_q,     fv_d;
  logic               jclk_q,   jclk_d;
  logic               load_n_q, load_n_d;
  logic               data_s;
  logic               tick_c;

  assign data_s = sync_q[1];
  assign tick_c = (div_q == DIV_W'(CLK_DIV - 1));

  // Register bank; reset parks the FSM in GAP so a full gap precedes the first load
  always_ff @(posedge clk50mhz or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= 2'b11;
      div_q    <= '0;
      state_q  <= ST_GAP;
      cnt_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      prev_q   <= '0;
      joy1_q   <= '0;
      joy2_q   <= '0;
      fv_q     <= 1'b0;
      jclk_q   <= 1'b0;
      load_n_q <= 1'b1;
    end else begin
      sync_q   <= {sync_q[0], joy_data};
      div_q    <= div_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      prev_q   <= prev_d;
      joy1_q   <= joy1_d;
      joy2_q   <= joy2_d;
      fv_q     <= fv_d;
      jclk_q   <= jclk_d;
      load_n_q <= load_n_d;
    end
  end

  // Next-state logic; the prescaler holds during COMPARE so that cycle adds to the frame
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    prev_d   = prev_q;
    joy1_d   = joy1_q;
    joy2_d   = joy2_q;
    fv_d     = 1'b0;
    jclk_d   = jclk_q;
    load_n_d = load_n_q;
    div_d    = (tick_c || state_q == ST_COMPARE) ? '0 : div_q + DIV_W'(1);

    case (state_q)
      ST_LOAD: begin
        if (tick_c) begin
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_SHIFT_LO;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_SHIFT_LO: begin
        if (tick_c) begin
          shreg_d = {shreg_q[FRAME_W-2:0], data_s};
          state_d = ST_SHIFT_HI;
        end
      end
      ST_SHIFT_HI: begin
        if (tick_c) begin
          bit_d   = bit_q + BIT_W'(1);
          state_d = (bit_q == BIT_W'(15)) ? ST_COMPARE : ST_SHIFT_LO;
        end
      end
      ST_COMPARE: begin
        if (shreg_q == prev_q) begin
          joy1_d = ~shreg_q[15:8];
          joy2_d = ~shreg_q[7:0];
          fv_d   = 1'b1;
        end
        prev_d  = shreg_q;
        state_d = ST_GAP;
      end
      ST_GAP: begin
        if (tick_c) begin
          if (cnt_q == CNT_W'(GAP_TICKS - 1)) begin
            state_d = ST_LOAD;
            cnt_d   = '0;
            bit_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_GAP;
    endcase

    if (tick_c) begin
      jclk_d   = (state_d == ST_SHIFT_HI);
      load_n_d = (state_d != ST_LOAD);
    end
  end

  assign joy_clk     = jclk_q;
  assign joy_load_n  = load_n_q;
  assign joy_select  = 1'b1;
  assign joy1        = joy1_q;
  assign joy2        = joy2_q;
  assign frame_valid = fv_q;

endmodule
